// File: rtl/red_pitaya_hk_led_gen2_if.sv
// System-bus bundle for the second-generation housekeeping block.
interface red_pitaya_hk_led_gen2_if;
   logic [31:0] sys_addr;
   logic [31:0] sys_wdata;
   logic        sys_wen;
   logic        sys_ren;
   logic [31:0] sys_rdata;
   logic        sys_err;
   logic        sys_ack;

   modport master (
      output sys_addr, sys_wdata, sys_wen, sys_ren,
      input  sys_rdata, sys_err, sys_ack
   );

   modport slave (
      input  sys_addr, sys_wdata, sys_wen, sys_ren,
      output sys_rdata, sys_err, sys_ack
   );
endinterface

// File: rtl/red_pitaya_hk_led_gen2.sv
// Housekeeping gen2: per-channel LED engine (off/on/PWM/blink) plus expansion GPIO on sys-bus.
// Optional triangle "breathe" mode 4 is built only when HK_LED_BREATHE_EN is defined.
module red_pitaya_hk_led_gen2 #(
   parameter int unsigned DWL  = 8,
   parameter int unsigned DWE  = 8,
   parameter int unsigned PWMW = 8,
   parameter int unsigned PRW  = 24
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   output logic [DWL-1:0]          led_o,
   input  logic [DWE-1:0]          exp_p_dat_i,
   output logic [DWE-1:0]          exp_p_dat_o,
   output logic [DWE-1:0]          exp_p_dir_o,
   input  logic [DWE-1:0]          exp_n_dat_i,
   output logic [DWE-1:0]          exp_n_dat_o,
   output logic [DWE-1:0]          exp_n_dir_o,
   red_pitaya_hk_led_gen2_if.slave bus
);
   localparam logic [31:0] ID = {8'h00, 8'(PWMW), 8'(DWL), 8'h04};

   logic [19:0]    addr;
   logic           strobe;
   logic [3:0]     ch_sel;
   logic           ch_hit;
   logic           hit;
   logic           ro;
   logic           acc_err;
   logic [31:0]    rd;
   logic           wr_pdir, wr_ndir, wr_pdo, wr_ndo, wr_gen, wr_presc;
   logic [DWL-1:0] wr_ch;
   logic [31:0]    ch_rd [DWL];

   logic [DWE-1:0] p_meta, p_sync, n_meta, n_sync;
   logic           gen;
   logic [PRW-1:0] presc;
   logic [PRW-1:0] pcnt;
   logic           tick;
   logic [PWMW-1:0] pc;
   logic [DWL-1:0] drive;
   logic           unused;

   assign addr   = bus.sys_addr[19:0];
   assign strobe = bus.sys_wen | bus.sys_ren;
   assign ch_sel = addr[5:2];
   assign ch_hit = (addr[19:6] == 14'h8) && (addr[1:0] == 2'b00) && (32'(ch_sel) < DWL);
   assign unused = ^{bus.sys_addr, bus.sys_wdata};

   // Address decode; RO writes and unmapped accesses flag an error and never strobe a register
   always_comb begin
      hit      = 1'b1;
      ro       = 1'b0;
      rd       = '0;
      wr_pdir  = 1'b0;
      wr_ndir  = 1'b0;
      wr_pdo   = 1'b0;
      wr_ndo   = 1'b0;
      wr_gen   = 1'b0;
      wr_presc = 1'b0;
      wr_ch    = '0;
      case (addr)
         20'h00000: begin rd = ID;                ro = 1'b1;               end
         20'h00010: begin rd = 32'(exp_p_dir_o);  wr_pdir  = bus.sys_wen;  end
         20'h00014: begin rd = 32'(exp_n_dir_o);  wr_ndir  = bus.sys_wen;  end
         20'h00018: begin rd = 32'(exp_p_dat_o);  wr_pdo   = bus.sys_wen;  end
         20'h0001C: begin rd = 32'(exp_n_dat_o);  wr_ndo   = bus.sys_wen;  end
         20'h00020: begin rd = 32'(p_sync);       ro = 1'b1;               end
         20'h00024: begin rd = 32'(n_sync);       ro = 1'b1;               end
         20'h00030: begin rd = 32'(gen);          wr_gen   = bus.sys_wen;  end
         20'h00034: begin rd = 32'(presc);        wr_presc = bus.sys_wen;  end
         default: begin
            hit = ch_hit;
            for (int unsigned k = 0; k < DWL; k++) begin
               if (ch_hit && (ch_sel == 4'(k))) begin
                  rd       = ch_rd[k];
                  wr_ch[k] = bus.sys_wen;
               end
            end
         end
      endcase
      acc_err = !hit || (ro && bus.sys_wen);
      if (acc_err) rd = '0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bus.sys_ack   <= 1'b0;
         bus.sys_err   <= 1'b0;
         bus.sys_rdata <= '0;
      end else begin
         bus.sys_ack <= strobe;
         bus.sys_err <= strobe & acc_err;
         if (strobe) bus.sys_rdata <= rd;
      end
   end

   // Global configuration registers; GEN comes out of reset enabled
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         exp_p_dir_o <= '0;
         exp_n_dir_o <= '0;
         exp_p_dat_o <= '0;
         exp_n_dat_o <= '0;
         gen         <= 1'b1;
         presc       <= '0;
      end else begin
         if (wr_pdir)  exp_p_dir_o <= bus.sys_wdata[DWE-1:0];
         if (wr_ndir)  exp_n_dir_o <= bus.sys_wdata[DWE-1:0];
         if (wr_pdo)   exp_p_dat_o <= bus.sys_wdata[DWE-1:0];
         if (wr_ndo)   exp_n_dat_o <= bus.sys_wdata[DWE-1:0];
         if (wr_gen)   gen         <= bus.sys_wdata[0];
         if (wr_presc) presc       <= bus.sys_wdata[PRW-1:0];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         p_meta <= '0;
         p_sync <= '0;
         n_meta <= '0;
         n_sync <= '0;
      end else begin
         p_meta <= exp_p_dat_i;
         p_sync <= p_meta;
         n_meta <= exp_n_dat_i;
         n_sync <= n_meta;
      end
   end

   assign tick = (pcnt == presc);

   // Blink prescaler; a PRESC write restarts the count so the new period starts clean
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pcnt <= '0;
         pc   <= '0;
      end else begin
         pc <= pc + PWMW'(1);
         if (wr_presc || tick) pcnt <= '0;
         else                  pcnt <= pcnt + PRW'(1);
      end
   end

   for (genvar k = 0; k < DWL; k++) begin : g_ch
      logic [2:0]      mode;
      logic [PWMW-1:0] duty;
      logic [7:0]      half;
      logic [7:0]      bc;
      logic [7:0]      lim;
      logic            ph;
      logic            br_pwm;

      assign lim = (half == 8'd0) ? 8'd0 : half - 8'd1;

      // A channel write outranks a coincident tick
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            mode <= '0;
            duty <= '0;
            half <= '0;
            bc   <= '0;
            ph   <= 1'b0;
         end else if (wr_ch[k]) begin
            mode <= bus.sys_wdata[2:0];
            duty <= bus.sys_wdata[8 +: PWMW];
            half <= bus.sys_wdata[23:16];
            bc   <= '0;
            ph   <= 1'b0;
         end else if (tick) begin
            if (bc >= lim) begin
               bc <= '0;
               ph <= ~ph;
            end else begin
               bc <= bc + 8'd1;
            end
         end
      end

`ifdef HK_LED_BREATHE_EN
      logic [PWMW-1:0] br;
      logic            up;
      logic            up_nxt;

      assign up_nxt = up ? (br != {PWMW{1'b1}}) : (br == '0);

      // Triangle ramp: turn around at either end on the same tick that reaches it
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            br <= '0;
            up <= 1'b1;
         end else if (wr_ch[k]) begin
            br <= '0;
            up <= 1'b1;
         end else if (tick) begin
            up <= up_nxt;
            br <= up_nxt ? br + PWMW'(1) : br - PWMW'(1);
         end
      end

      assign br_pwm = (pc < br);
`else
      assign br_pwm = 1'b0;
`endif

      assign drive[k] = (mode == 3'd1)
                      | ((mode == 3'd2) & (pc < duty))
                      | ((mode == 3'd3) & ph)
                      | ((mode == 3'd4) & br_pwm);

      assign ch_rd[k] = {8'h00, half, 8'(duty), 5'h00, mode};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) led_o <= '0;
      else       led_o <= gen ? drive : '0;
   end
endmodule

// File: tb/tb_red_pitaya_hk_led_gen2.sv
// Self-checking bench: bus vector table with a response scoreboard, plus LED/GPIO timing sequences.
`timescale 1ns/1ps
module tb_red_pitaya_hk_led_gen2;
   localparam int unsigned DWL  = 8;
   localparam int unsigned DWE  = 8;
   localparam int unsigned PWMW = 8;
   localparam int unsigned PRW  = 24;

   logic           clk = 1'b0;
   logic           rst;
   logic [DWL-1:0] led;
   logic [DWE-1:0] p_in, p_out, p_dir, n_in, n_out, n_dir;

   red_pitaya_hk_led_gen2_if bus();

   red_pitaya_hk_led_gen2 #(.DWL(DWL), .DWE(DWE), .PWMW(PWMW), .PRW(PRW)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .led_o       (led),
      .exp_p_dat_i (p_in),
      .exp_p_dat_o (p_out),
      .exp_p_dir_o (p_dir),
      .exp_n_dat_i (n_in),
      .exp_n_dat_o (n_out),
      .exp_n_dir_o (n_dir),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        chk;
      logic [31:0] rd;
      logic        err;
      logic [31:0] addr;
   } exp_t;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Responses are matched in order against what each bus_op queued
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.sys_ack) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", 32'(bus.sys_ack), 32'd0);
         end else begin
            e = sb.pop_front();
            check($sformatf("err@%05h", e.addr[19:0]), 32'(bus.sys_err), 32'(e.err));
            if (e.chk) check($sformatf("rdata@%05h", e.addr[19:0]), bus.sys_rdata, e.rd);
         end
      end
   end

   task automatic bus_op(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic chk, input logic [31:0] r, input logic e);
      exp_t x;
      @(posedge clk); #1;
      bus.sys_addr  = a;
      bus.sys_wdata = d;
      bus.sys_wen   = wr;
      bus.sys_ren   = !wr;
      x.chk = chk; x.rd = r; x.err = e; x.addr = a;
      sb.push_back(x);
   endtask

   task automatic bus_idle();
      @(posedge clk); #1;
      bus.sys_wen = 1'b0;
      bus.sys_ren = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      check("sb_drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vt[$];
      int   hi, lo, rises, cnt;
      logic prev, found;

      vt.push_back('{1'b0, 32'h000, 32'h0,        1'b1, 32'h0008_0804, 1'b0});
      vt.push_back('{1'b0, 32'h030, 32'h0,        1'b1, 32'h0000_0001, 1'b0});
      vt.push_back('{1'b0, 32'h034, 32'h0,        1'b1, 32'h0000_0000, 1'b0});
      vt.push_back('{1'b1, 32'h010, 32'h0F,       1'b0, 32'h0,         1'b0});
      vt.push_back('{1'b0, 32'h010, 32'h0,        1'b1, 32'h0000_000F, 1'b0});
      vt.push_back('{1'b1, 32'h014, 32'hF0,       1'b0, 32'h0,         1'b0});
      vt.push_back('{1'b0, 32'h014, 32'h0,        1'b1, 32'h0000_00F0, 1'b0});
      vt.push_back('{1'b1, 32'h018, 32'h155,      1'b0, 32'h0,         1'b0});
      vt.push_back('{1'b0, 32'h018, 32'h0,        1'b1, 32'h0000_0055, 1'b0});
      vt.push_back('{1'b1, 32'h01C, 32'hAA,       1'b0, 32'h0,         1'b0});
      vt.push_back('{1'b0, 32'h01C, 32'h0,        1'b1, 32'h0000_00AA, 1'b0});
      vt.push_back('{1'b1, 32'h208, 32'hFF12_40FA, 1'b0, 32'h0,        1'b0});
      vt.push_back('{1'b0, 32'h208, 32'h0,        1'b1, 32'h0012_4002, 1'b0});
      vt.push_back('{1'b1, 32'h21C, 32'h0000_0007, 1'b0, 32'h0,        1'b0});
      vt.push_back('{1'b0, 32'h21C, 32'h0,        1'b1, 32'h0000_0007, 1'b0});
      vt.push_back('{1'b0, 32'h220, 32'h0,        1'b1, 32'h0,         1'b1});
      vt.push_back('{1'b1, 32'h220, 32'h1,        1'b1, 32'h0,         1'b1});
      vt.push_back('{1'b1, 32'h020, 32'hFF,       1'b1, 32'h0,         1'b1});
      vt.push_back('{1'b0, 32'h020, 32'h0,        1'b1, 32'h0,         1'b0});
      vt.push_back('{1'b1, 32'h000, 32'h1234,     1'b1, 32'h0,         1'b1});
      vt.push_back('{1'b0, 32'h000, 32'h0,        1'b1, 32'h0008_0804, 1'b0});
      vt.push_back('{1'b0, 32'h0FC, 32'h0,        1'b1, 32'h0,         1'b1});
      vt.push_back('{1'b0, 32'h202, 32'h0,        1'b1, 32'h0,         1'b1});
      vt.push_back('{1'b0, 32'h0010_0030, 32'h0,  1'b1, 32'h0000_0001, 1'b0});
      vt.push_back('{1'b1, 32'h034, 32'hFFFF_FFFF, 1'b0, 32'h0,        1'b0});
      vt.push_back('{1'b0, 32'h034, 32'h0,        1'b1, 32'h00FF_FFFF, 1'b0});

      rst = 1'b1;
      p_in = '0;
      n_in = '0;
      bus.sys_addr = '0; bus.sys_wdata = '0; bus.sys_wen = 1'b0; bus.sys_ren = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_led",   32'(led),   32'd0);
      check("reset_pdir",  32'(p_dir), 32'd0);
      check("reset_ndir",  32'(n_dir), 32'd0);
      check("reset_pout",  32'(p_out), 32'd0);
      check("reset_ack",   32'(bus.sys_ack),   32'd0);
      check("reset_rdata", bus.sys_rdata,      32'd0);
      #1 rst = 1'b0;

      // Register map and error vectors, issued back-to-back
      for (int i = 0; i < vt.size(); i++)
         bus_op(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].chk, vt[i].rd, vt[i].err);
      bus_idle();
      drain();
      check("pdir_out", 32'(p_dir), 32'h0F);
      check("ndir_out", 32'(n_dir), 32'hF0);
      check("pdat_out", 32'(p_out), 32'h55);
      check("ndat_out", 32'(n_out), 32'hAA);

      // CH2 PWM duty 0x40 (already programmed by the table)
      repeat (4) @(posedge clk);
      @(negedge clk); prev = led[2]; hi = 0; rises = 0;
      repeat (512) begin
         @(negedge clk);
         if (led[2]) hi++;
         if (led[2] && !prev) rises++;
         prev = led[2];
      end
      check("pwm40_high", 32'(hi), 32'd128);
      check("pwm40_runs", 32'(rises), 32'd2);

      bus_op(1'b1, 32'h208, 32'h0000_0002, 1'b0, 32'h0, 1'b0);
      bus_idle();
      repeat (4) @(posedge clk);
      hi = 0;
      repeat (256) begin @(negedge clk); if (led[2]) hi++; end
      check("pwm00_high", 32'(hi), 32'd0);

      bus_op(1'b1, 32'h208, 32'h0000_FF02, 1'b0, 32'h0, 1'b0);
      bus_idle();
      repeat (4) @(posedge clk);
      lo = 0;
      repeat (256) begin @(negedge clk); if (!led[2]) lo++; end
      check("pwmff_low", 32'(lo), 32'd1);
      bus_op(1'b1, 32'h208, 32'h0, 1'b0, 32'h0, 1'b0);

      // Blink: PRESC=3, half=2 -> 8-cycle half period
      bus_op(1'b1, 32'h034, 32'h3, 1'b0, 32'h0, 1'b0);
      bus_op(1'b1, 32'h200, 32'h0002_0003, 1'b0, 32'h0, 1'b0);
      bus_idle();
      @(negedge clk); prev = led[0]; found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (led[0] != prev) found = 1'b1;
         prev = led[0];
      end
      check("blink_start", 32'(found), 32'd1);
      for (int t = 0; t < 4; t++) begin
         cnt = 0; found = 1'b0;
         for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk); cnt++;
            if (led[0] != prev) found = 1'b1;
            prev = led[0];
         end
         check($sformatf("blink_interval%0d", t), 32'(cnt), 32'd8);
      end

      // GEN=0 blanks every LED within two cycles while channel state keeps running
      bus_op(1'b1, 32'h030, 32'h0, 1'b0, 32'h0, 1'b0);
      bus_op(1'b1, 32'h204, 32'h0000_0001, 1'b0, 32'h0, 1'b0);
      bus_idle();
      @(negedge clk);
      check("gen_off_led", 32'(led), 32'd0);
      hi = 0;
      repeat (30) begin @(negedge clk); if (led != '0) hi++; end
      check("gen_off_hold", 32'(hi), 32'd0);
      bus_op(1'b1, 32'h030, 32'h1, 1'b0, 32'h0, 1'b0);
      bus_idle();
      repeat (2) @(negedge clk);
      check("gen_on_ch1", 32'(led[1]), 32'd1);
      prev = led[0]; found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (led[0] != prev) found = 1'b1;
         prev = led[0];
      end
      check("blink_kept_running", 32'(found), 32'd1);
      drain();

      // Expansion inputs through the synchroniser: change lands on the third read
      p_in = 8'hA5;
      n_in = 8'h3C;
      repeat (4) @(posedge clk);
      bus_op(1'b0, 32'h020, 32'h0, 1'b1, 32'h0000_00A5, 1'b0);
      bus_op(1'b0, 32'h024, 32'h0, 1'b1, 32'h0000_003C, 1'b0);
      bus_op(1'b0, 32'h020, 32'h0, 1'b1, 32'h0000_00A5, 1'b0);
      p_in = 8'h5A;
      bus_op(1'b0, 32'h020, 32'h0, 1'b1, 32'h0000_00A5, 1'b0);
      bus_op(1'b0, 32'h020, 32'h0, 1'b1, 32'h0000_005A, 1'b0);
      bus_op(1'b1, 32'h020, 32'h0, 1'b1, 32'h0,         1'b1);
      bus_op(1'b0, 32'h020, 32'h0, 1'b1, 32'h0000_005A, 1'b0);
      bus_idle();
      drain();

      // Mode 4: ramps under HK_LED_BREATHE_EN, otherwise stays dark
      bus_op(1'b1, 32'h034, 32'h0, 1'b0, 32'h0, 1'b0);
      bus_op(1'b1, 32'h204, 32'h0000_0004, 1'b0, 32'h0, 1'b0);
      bus_idle();
      repeat (2) @(posedge clk);
      hi = 0;
      repeat (1024) begin @(negedge clk); if (led[1]) hi++; end
`ifdef HK_LED_BREATHE_EN
      check("breathe_active", 32'((hi > 0) && (hi < 1024)), 32'd1);
`else
      check("breathe_off", 32'(hi), 32'd0);
`endif
      drain();

      // Mid-operation reset clears everything immediately
      bus_op(1'b1, 32'h208, 32'h0000_0001, 1'b0, 32'h0, 1'b0);
      bus_idle();
      drain();
      check("pre_reset_ch2", 32'(led[2]), 32'd1);
      #2 rst = 1'b1;
      #1 check("reset_async_led", 32'(led), 32'd0);
      repeat (2) @(negedge clk);
      check("reset_hold_led", 32'(led), 32'd0);
      #1 rst = 1'b0;
      bus_op(1'b0, 32'h208, 32'h0, 1'b1, 32'h0,          1'b0);
      bus_op(1'b0, 32'h030, 32'h0, 1'b1, 32'h0000_0001,  1'b0);
      bus_op(1'b0, 32'h010, 32'h0, 1'b1, 32'h0,          1'b0);
      bus_idle();
      drain();
      check("post_reset_led", 32'(led), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/red_pitaya_hk_led_gen2.md
Name: red_pitaya_hk_led_gen2

Overview:
Second-generation housekeeping block with a parametrised LED engine and expansion-connector GPIO, all on the system bus. Each LED channel has its own mode register: off, on, PWM dimming or prescaled blink. Expansion inputs are synchronised. Unmapped or out-of-range bus accesses return an error. It sits beside the classic housekeeping on its own sys-bus slot.

Parameters:
DWL, 8, LED channel count (1..16).
DWE, 8, expansion bank width per polarity (1..32).
PWMW, 8, PWM resolution in bits (2..8).
PRW, 24, blink prescaler width (1..32).

Ports:
clk_i  in  1  system clock.
rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
led_o  out  DWL  LED drive, registered.
exp_p_dat_i  in  DWE  P-side inputs, asynchronous.
exp_p_dat_o  out  DWE  P-side output data.
exp_p_dir_o  out  DWE  P-side output enable, 1 = drive.
exp_n_dat_i  in  DWE  N-side inputs, asynchronous.
exp_n_dat_o  out  DWE  N-side output data.
exp_n_dir_o  out  DWE  N-side output enable.
sys_addr  in  32  bus address, decode on [19:0].
sys_wdata  in  32  write data.
sys_wen  in  1  write strobe.
sys_ren  in  1  read strobe.
sys_rdata  out  32  read data, registered.
sys_err  out  1  error, valid with sys_ack.
sys_ack  out  1  acknowledge.

Behaviour:
- Reset values: all outputs 0, sys_rdata 0, all registers 0; exception: LED global enable (GEN) resets to 1.
- Bus timing:
  - sys_ack = registered (sys_wen|sys_ren), one cycle after the strobe.
  - sys_rdata and sys_err update in that same cycle.
  - Back-to-back strobes give back-to-back acks.
  - A write takes effect on the cycle sys_ack rises.
- Register map (byte offsets; unused bits read 0):
  - 0x000 ID, RO: {8'h0, PWMW[7:0], DWL[7:0], 8'h04}.
  - 0x010 exp_p_dir, RW.
  - 0x014 exp_n_dir, RW.
  - 0x018 exp_p_dat_o, RW.
  - 0x01C exp_n_dat_o, RW.
  - 0x020 exp_p_dat_i (synchronised), RO.
  - 0x024 exp_n_dat_i (synchronised), RO.
  - 0x030 GEN: bit 0, RW.
  - 0x034 PRESC: [PRW-1:0], RW.
  - 0x200+4k, k<DWL: CHk control, RW.
    - [2:0] mode.
    - [8+:PWMW] duty.
    - [23:16] half-period.
- Errors:
  - Any access outside the map, including CHk with k>=DWL, gives ack=1, err=1, rdata 0. Writes there are dropped.
  - A write to a RO register gives ack=1, err=1 and no state change.
- Expansion inputs: 2-FF synchroniser; a read returns the pin state from 3 cycles earlier.
- Prescaler:
  - Counter counts 0..PRESC, then wraps.
  - tick=1 for one cycle when counter==PRESC; PRESC=0 gives tick every cycle.
  - Writing PRESC clears the counter.
- PWM:
  - Shared free-running counter pc, PWMW bits, increments every cycle and wraps.
  - pwm_k = (pc < duty_k).
  - duty 0 is always off; duty 2^PWMW-1 is off 1 cycle per 2^PWMW.
- Per-channel blink state:
  - Counter bc_k (8b) and phase ph_k.
  - On tick: if bc_k >= max(half_k,1)-1, then bc_k<=0 and ph_k toggles; else bc_k++.
  - Writing CHk clears bc_k and ph_k.
- Mode decode, then led_o[k] registered one cycle later:
  - 0 off.
  - 1 on.
  - 2 pwm_k.
  - 3 ph_k.
  - 4 breathe (see Optional Feature).
  - 5..7 off.
  - GEN=0 forces all led_o to 0; channel state keeps running.
- Simultaneous events: a write to CHk coinciding with tick means the write wins and tick is ignored for k.
- Reset mid-operation: all counters clear immediately; led_o is 0 while rst_i is high.

Optional Feature:
HK_LED_BREATHE_EN.
- Defined:
  - Mode 4 drives the channel with a triangle-ramped duty br_k (PWMW bits), used in place of duty in the PWM compare.
  - On each tick br_k steps ±1, between 0 and 2^PWMW-1, reversing direction at each end.
  - Writing CHk sets br_k=0 and direction up.
- Undefined: mode 4 drives off; no br_k logic is built.

Test Plan:
- Reset with GEN=1; read 0x000 with defaults -> rdata 0x00080804, err 0; led_o 0.
- Write CH2 mode=2, duty=0x40 -> led_o[2] high 64 of every 256 cycles, phase-locked to pc. Duty=0 -> constant 0. Duty=0xFF -> exactly 1 low cycle per 256.
- PRESC=3, CH0 mode=3, half=2 -> led_o[0] toggles every 8 cycles. Then write GEN=0 -> led_o all 0 within 2 cycles.
- Read 0x200+4*8 with DWL=8 -> ack=1, err=1, rdata 0. Write 0x020 -> err=1, no change. Read 0x0FC -> err=1.
- Drive exp_p_dat_i=0xA5, read 0x020 after >=3 cycles -> 0xA5. Write exp_p_dir=0x0F -> readback 0x0F, exp_p_dir_o=0x0F.
- Define HK_LED_BREATHE_EN, PRESC=0, CH1 mode=4 -> br_1 goes 0..255..0 with a 510-tick period. Without the macro -> led_o[1] stays 0.
